// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - byte-wide req/ack data-memory bus between the LSU and memory
interface load_store_unit_if #(
  parameter int ADDR_W = 32
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        wdata;
  logic [7:0]        rdata;
  logic              ack;

  modport master (output req, we, addr, wdata, input rdata, ack);
  modport slave  (input req, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - splits word/halfword/byte loads and stores into byte bus transfers
// LSU_MISALIGN_TRAP_EN: misaligned halfword/word accesses raise err instead of being force-aligned.
module load_store_unit #(
  parameter int ADDR_W     = 32,
  parameter int BIG_ENDIAN = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              memread,
  input  logic              memwrite,
  input  logic [1:0]        dS,
  input  logic              btX,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  load_store_unit_if.master mem
);
  typedef enum logic [1:0] {IDLE, XFER, DONE, ERR} state_t;

  function automatic logic [1:0] last_idx(input logic [1:0] size);
    case (size)
      2'b00:   return 2'd3;
      2'b01:   return 2'd1;
      default: return 2'd0;
    endcase
  endfunction

  // Byte position of transfer k inside the assembled value; big-endian puts byte 0 on top.
  function automatic logic [1:0] slot(input logic [1:0] k, input logic [1:0] size);
    return (BIG_ENDIAN != 0) ? last_idx(size) - k : k;
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] v, input logic [1:0] size,
                                         input logic sx);
    case (size)
      2'b01:   return {{16{sx & v[15]}}, v[15:0]};
      2'b10:   return {{24{sx & v[7]}}, v[7:0]};
      default: return v;
    endcase
  endfunction

  state_t            state_q, state_d;
  logic [1:0]        k_q, k_d;
  logic [1:0]        size_q, size_d;
  logic              btx_q, btx_d;
  logic              store_q, store_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       buf_q, buf_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] maddr_q, maddr_d;
  logic [7:0]        mwdata_q, mwdata_d;

  logic              bad_access;
  logic [ADDR_W-1:0] base_addr;

  always_comb begin
    base_addr = addr;
    if (dS == 2'b00) base_addr = {addr[ADDR_W-1:2], 2'b00};
    else if (dS == 2'b01) base_addr = {addr[ADDR_W-1:1], 1'b0};
`ifdef LSU_MISALIGN_TRAP_EN
    bad_access = (memread == memwrite) || (dS == 2'b11) ||
                 (dS == 2'b01 && addr[0]) || (dS == 2'b00 && addr[1:0] != 2'b00);
`else
    bad_access = (memread == memwrite) || (dS == 2'b11);
`endif
  end

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    size_d   = size_q;
    btx_d    = btx_q;
    store_d  = store_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    buf_d    = buf_q;
    rdata_d  = rdata_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    req_d    = req_q;
    we_d     = we_q;
    maddr_d  = maddr_q;
    mwdata_d = mwdata_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          size_d  = dS;
          btx_d   = btX;
          store_d = memwrite;
          wdata_d = wdata;
          addr_d  = base_addr;
          buf_d   = '0;
          k_d     = 2'd0;
          busy_d  = 1'b1;
          if (bad_access) begin
            state_d = ERR;
            err_d   = 1'b1;
          end else begin
            state_d  = XFER;
            req_d    = 1'b1;
            we_d     = memwrite;
            maddr_d  = base_addr;
            mwdata_d = wdata[{slot(2'd0, dS), 3'b000} +: 8];
          end
        end
      end
      XFER: begin
        if (req_q && mem.ack) begin
          buf_d[{slot(k_q, size_q), 3'b000} +: 8] = mem.rdata;
          if (k_q == last_idx(size_q)) begin
            state_d = DONE;
            req_d   = 1'b0;
            we_d    = 1'b0;
            done_d  = 1'b1;
            if (!store_q) rdata_d = extend(buf_d, size_q, btx_q);
          end else begin
            k_d      = k_q + 2'd1;
            maddr_d  = addr_q + ADDR_W'(k_d);
            mwdata_d = wdata_q[{slot(k_d, size_q), 3'b000} +: 8];
          end
        end
      end
      DONE, ERR: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      k_q      <= '0;
      size_q   <= '0;
      btx_q    <= 1'b0;
      store_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      buf_q    <= '0;
      rdata_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      maddr_q  <= '0;
      mwdata_q <= '0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      size_q   <= size_d;
      btx_q    <= btx_d;
      store_q  <= store_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      buf_q    <= buf_d;
      rdata_q  <= rdata_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      req_q    <= req_d;
      we_q     <= we_d;
      maddr_q  <= maddr_d;
      mwdata_q <= mwdata_d;
    end
  end

  assign rdata     = rdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign mem.req   = req_q;
  assign mem.we    = we_q;
  assign mem.addr  = maddr_q;
  assign mem.wdata = mwdata_q;
endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench for load_store_unit with a byte-memory model
module tb_load_store_unit;
  localparam int ADDR_W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start, memread, memwrite, btX;
  logic [1:0]  dS;
  logic [31:0] addr, wdata, rdata;
  logic        busy, done, err;

  load_store_unit_if #(.ADDR_W(ADDR_W)) mif ();

  load_store_unit #(.ADDR_W(ADDR_W), .BIG_ENDIAN(0)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .memread  (memread),
    .memwrite (memwrite),
    .dS       (dS),
    .btX      (btX),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .mem      (mif.master)
  );

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  logic [7:0]  mem_model [logic [31:0]];
  logic [7:0]  ref_mem   [logic [31:0]];
  int          ack_delay   = 0;
  int          wait_cnt    = 0;
  logic        pending     = 1'b0;
  logic [31:0] p_addr;
  logic        p_we;
  logic [7:0]  p_wd;
  int          stable_viol = 0;
  int          done_cnt    = 0;
  int          err_cnt     = 0;
  logic [31:0] q_addr[$];
  logic        q_we[$];
  logic [7:0]  q_wd[$];
  int          q_cyc[$];
  logic [31:0] exp_rdata = 32'h0;

  logic        got_done, got_err;
  int          lat, start_cyc;

  initial forever @(posedge clk) cyc++;

  // Memory responder: decides ack on the negative edge and logs every completed byte transfer.
  initial begin
    mif.ack   = 1'b0;
    mif.rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (done) done_cnt++;
      if (err) err_cnt++;
      if (mif.req === 1'b1) begin
        if (pending && (mif.addr !== p_addr || mif.we !== p_we || mif.wdata !== p_wd))
          stable_viol++;
        if (wait_cnt >= ack_delay) begin
          mif.ack   = 1'b1;
          mif.rdata = mem_model.exists(mif.addr) ? mem_model[mif.addr] : 8'h00;
          q_addr.push_back(mif.addr);
          q_we.push_back(mif.we);
          q_wd.push_back(mif.wdata);
          q_cyc.push_back(cyc);
          if (mif.we) mem_model[mif.addr] = mif.wdata;
          wait_cnt = 0;
          pending  = 1'b0;
        end else begin
          if (!pending) begin
            p_addr = mif.addr;
            p_we   = mif.we;
            p_wd   = mif.wdata;
          end
          pending   = 1'b1;
          mif.ack   = 1'b0;
          mif.rdata = 8'($urandom);
          wait_cnt++;
        end
      end else begin
        mif.ack   = (ack_delay == 0);
        mif.rdata = 8'($urandom);
        wait_cnt  = 0;
        pending   = 1'b0;
      end
    end
  end

  function automatic int nbytes(input logic [1:0] ds);
    return (ds == 2'b00) ? 4 : (ds == 2'b01) ? 2 : 1;
  endfunction

  function automatic logic ref_bad(input logic r, input logic w, input logic [1:0] ds,
                                   input logic [31:0] a);
    logic bad;
    bad = (r == w) || (ds == 2'b11);
`ifdef LSU_MISALIGN_TRAP_EN
    if (ds != 2'b11 && (a % nbytes(ds)) != 0) bad = 1'b1;
`endif
    return bad;
  endfunction

  function automatic logic [31:0] ref_base(input logic [31:0] a, input logic [1:0] ds);
    return a - (a % nbytes(ds));
  endfunction

  // Little-endian assembly, then two's-complement extension from the access width.
  function automatic logic [31:0] ref_load(input logic [31:0] base, input int n, input logic sx);
    logic [31:0] v;
    v = 32'h0;
    for (int k = 0; k < n; k++)
      v = v + ((ref_mem.exists(base + k) ? 32'(ref_mem[base + k]) : 32'h0) << (8 * k));
    if (sx && n < 4 && v[8 * n - 1]) v = v | (32'hFFFFFFFF << (8 * n));
    return v;
  endfunction

  task automatic poke(input logic [31:0] a, input logic [7:0] b);
    mem_model[a] = b;
    ref_mem[a]   = b;
  endtask

  task automatic run_op(input logic r, input logic w, input logic [1:0] ds, input logic bx,
                        input logic [31:0] a, input logic [31:0] wd);
    int guard;
    q_addr.delete(); q_we.delete(); q_wd.delete(); q_cyc.delete();
    @(negedge clk);
    start = 1'b1; memread = r; memwrite = w; dS = ds; btX = bx; addr = a; wdata = wd;
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0; memread = 1'($urandom); memwrite = 1'($urandom); addr = $urandom;
    lat = 1; got_done = 1'b0; got_err = 1'b0; guard = 0;
    while (!got_done && !got_err && guard < 200) begin
      if (done) got_done = 1'b1;
      else if (err) got_err = 1'b1;
      else begin
        @(negedge clk);
        lat++;
        guard++;
      end
    end
  endtask

  task automatic test_reset;
    checks++; if (rdata !== 32'h0) begin fails++; $display("FAIL reset_rdata got %h exp 0", rdata); end
    checks++; if ({busy, done, err} !== 3'b000) begin fails++; $display("FAIL reset_flags got %b exp 000", {busy, done, err}); end
    checks++; if ({mif.req, mif.we} !== 2'b00) begin fails++; $display("FAIL reset_req_we got %b exp 00", {mif.req, mif.we}); end
    checks++; if (mif.addr !== 32'h0 || mif.wdata !== 8'h0) begin fails++; $display("FAIL reset_bus got %h/%h exp 0/0", mif.addr, mif.wdata); end
    rst = 1'b0;
  endtask

  task automatic test_word_load;
    poke(32'h100, 8'h78); poke(32'h101, 8'h56); poke(32'h102, 8'h34); poke(32'h103, 8'h12);
    ack_delay = 0;
    run_op(1'b1, 1'b0, 2'b00, 1'b1, 32'h100, 32'h0);
    checks++; if (!got_done || lat != 5) begin fails++; $display("FAIL word_load_latency got done=%0b lat=%0d exp done=1 lat=5", got_done, lat); end
    checks++;
    if (q_addr.size() != 4) begin fails++; $display("FAIL word_load_count got %0d exp 4", q_addr.size()); end
    else for (int k = 0; k < 4; k++)
      if (q_addr[k] !== 32'h100 + k || q_cyc[k] - start_cyc != k + 1) begin
        fails++; $display("FAIL word_load_xfer%0d got %h@%0d exp %h@%0d", k, q_addr[k], q_cyc[k] - start_cyc, 32'h100 + k, k + 1);
      end
    exp_rdata = 32'h12345678;
    checks++; if (rdata !== exp_rdata) begin fails++; $display("FAIL word_load_rdata got %h exp %h", rdata, exp_rdata); end
  endtask

  task automatic test_byte_load;
    poke(32'h203, 8'h80);
    run_op(1'b1, 1'b0, 2'b10, 1'b1, 32'h203, 32'h0);
    checks++; if (!got_done || lat != 2) begin fails++; $display("FAIL byte_load_latency got done=%0b lat=%0d exp 1/2", got_done, lat); end
    checks++; if (rdata !== 32'hFFFFFF80) begin fails++; $display("FAIL byte_load_sext got %h exp ffffff80", rdata); end
    run_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h203, 32'h0);
    exp_rdata = 32'h00000080;
    checks++; if (rdata !== exp_rdata) begin fails++; $display("FAIL byte_load_zext got %h exp %h", rdata, exp_rdata); end
  endtask

  task automatic test_halfword_store;
    int d0;
    ack_delay = 3; stable_viol = 0; d0 = done_cnt;
    run_op(1'b0, 1'b1, 2'b01, 1'b0, 32'h10, 32'hDEADBEEF);
    repeat (3) @(negedge clk);
    checks++; if (!got_done || lat != 9) begin fails++; $display("FAIL hw_store_latency got done=%0b lat=%0d exp 1/9", got_done, lat); end
    checks++;
    if (q_addr.size() != 2) begin fails++; $display("FAIL hw_store_count got %0d exp 2", q_addr.size()); end
    else if (q_addr[0] !== 32'h10 || q_wd[0] !== 8'hEF || q_addr[1] !== 32'h11 || q_wd[1] !== 8'hBE || !q_we[0] || !q_we[1]) begin
      fails++; $display("FAIL hw_store_bytes got %h@%h %h@%h exp ef@10 be@11", q_wd[0], q_addr[0], q_wd[1], q_addr[1]);
    end
    checks++; if (stable_viol != 0) begin fails++; $display("FAIL hw_store_stable got %0d changes exp 0", stable_viol); end
    checks++; if (done_cnt - d0 != 1) begin fails++; $display("FAIL hw_store_done_count got %0d exp 1", done_cnt - d0); end
    checks++; if (rdata !== exp_rdata) begin fails++; $display("FAIL hw_store_rdata got %h exp %h", rdata, exp_rdata); end
    ref_mem[32'h10] = 8'hEF; ref_mem[32'h11] = 8'hBE;
    ack_delay = 0;
  endtask

  task automatic test_errors;
    run_op(1'b1, 1'b1, 2'b00, 1'b0, 32'h100, 32'h0);
    checks++; if (!got_err || got_done || lat != 1 || q_addr.size() != 0) begin
      fails++; $display("FAIL err_both got err=%0b lat=%0d xfers=%0d exp err=1 lat=1 xfers=0", got_err, lat, q_addr.size());
    end
    run_op(1'b1, 1'b0, 2'b11, 1'b0, 32'h100, 32'h0);
    checks++; if (!got_err || got_done || lat != 1 || q_addr.size() != 0) begin
      fails++; $display("FAIL err_ds11 got err=%0b lat=%0d xfers=%0d exp err=1 lat=1 xfers=0", got_err, lat, q_addr.size());
    end
    run_op(1'b0, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
    checks++; if (!got_err || q_addr.size() != 0) begin fails++; $display("FAIL err_none got err=%0b xfers=%0d exp 1/0", got_err, q_addr.size()); end
    checks++; if (rdata !== exp_rdata) begin fails++; $display("FAIL err_rdata got %h exp %h", rdata, exp_rdata); end
    run_op(1'b1, 1'b0, 2'b00, 1'b0, 32'h102, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
    checks++; if (!got_err || q_addr.size() != 0) begin fails++; $display("FAIL misalign_trap got err=%0b xfers=%0d exp 1/0", got_err, q_addr.size()); end
`else
    checks++;
    if (!got_done || q_addr.size() != 4) begin fails++; $display("FAIL misalign_fix got done=%0b xfers=%0d exp 1/4", got_done, q_addr.size()); end
    else if (q_addr[0] !== 32'h100 || q_addr[3] !== 32'h103) begin fails++; $display("FAIL misalign_addr got %h..%h exp 100..103", q_addr[0], q_addr[3]); end
    exp_rdata = ref_load(32'h100, 4, 1'b0);
    checks++; if (rdata !== exp_rdata) begin fails++; $display("FAIL misalign_rdata got %h exp %h", rdata, exp_rdata); end
`endif
  endtask

  task automatic test_reset_mid;
    int guard;
    poke(32'h300, 8'hA1); poke(32'h301, 8'hB2); poke(32'h302, 8'hC3); poke(32'h303, 8'hD4);
    ack_delay = 2;
    q_addr.delete(); q_we.delete(); q_wd.delete(); q_cyc.delete();
    @(negedge clk);
    start = 1'b1; memread = 1'b1; memwrite = 1'b0; dS = 2'b00; btX = 1'b0; addr = 32'h300;
    @(negedge clk);
    start = 1'b0;
    guard = 0;
    while (q_addr.size() < 2 && guard < 100) begin @(negedge clk); guard++; end
    @(negedge clk);
    checks++; if (mif.req !== 1'b1 || mif.addr !== 32'h302) begin fails++; $display("FAIL rst_mid_inflight got req=%0b addr=%h exp 1/302", mif.req, mif.addr); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if ({mif.req, busy, done} !== 3'b000 || rdata !== 32'h0) begin
      fails++; $display("FAIL rst_mid_abort got req/busy/done=%b rdata=%h exp 000/0", {mif.req, busy, done}, rdata);
    end
    rst = 1'b0; exp_rdata = 32'h0; ack_delay = 0;
    run_op(1'b1, 1'b0, 2'b00, 1'b0, 32'h300, 32'h0);
    exp_rdata = 32'hD4C3B2A1;
    checks++; if (!got_done || rdata !== exp_rdata) begin fails++; $display("FAIL rst_mid_restart got done=%0b rdata=%h exp 1/%h", got_done, rdata, exp_rdata); end
  endtask

  task automatic test_start_while_busy;
    int d0, e0;
    ack_delay = 1; d0 = done_cnt; e0 = err_cnt;
    q_addr.delete(); q_we.delete(); q_wd.delete(); q_cyc.delete();
    @(negedge clk);
    start = 1'b1; memread = 1'b1; memwrite = 1'b0; dS = 2'b00; btX = 1'b0; addr = 32'h300;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      start = busy; memread = 1'b0; memwrite = 1'b1; dS = 2'b10; addr = 32'h500; wdata = $urandom;
    end
    start = 1'b0;
    checks++; if (done_cnt - d0 != 1 || err_cnt != e0) begin fails++; $display("FAIL busy_start_pulses got done=%0d err=%0d exp 1/0", done_cnt - d0, err_cnt - e0); end
    checks++; if (q_addr.size() != 4 || q_we.sum() != 0) begin fails++; $display("FAIL busy_start_xfers got %0d xfers exp 4 reads", q_addr.size()); end
    checks++; if (rdata !== exp_rdata) begin fails++; $display("FAIL busy_start_rdata got %h exp %h", rdata, exp_rdata); end
    ack_delay = 0;
  endtask

  task automatic test_random;
    logic        r, w, bx, bad;
    logic [1:0]  ds;
    logic [31:0] a, wd, base, want;
    int          n, sel;
    for (int i = 0; i < 32; i++) poke(32'h400 + i, 8'($urandom));
    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 7);
      r  = (sel == 0) ? 1'b1 : (sel == 1) ? 1'b0 : sel[0];
      w  = (sel == 0) ? 1'b1 : (sel == 1) ? 1'b0 : !sel[0];
      ds = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      a  = 32'h400 + $urandom_range(0, 31);
      wd = $urandom; bx = 1'($urandom);
      ack_delay = $urandom_range(0, 2);
      bad  = ref_bad(r, w, ds, a);
      n    = nbytes(ds);
      base = ref_base(a, ds);
      want = (!bad && r) ? ref_load(base, n, bx) : exp_rdata;
      run_op(r, w, ds, bx, a, wd);
      checks++; if (got_err !== bad || got_done !== !bad) begin
        fails++; $display("FAIL rand%0d_outcome got done=%0b err=%0b exp err=%0b", i, got_done, got_err, bad);
      end
      checks++;
      if (q_addr.size() != (bad ? 0 : n)) begin fails++; $display("FAIL rand%0d_count got %0d exp %0d", i, q_addr.size(), bad ? 0 : n); end
      else for (int k = 0; k < q_addr.size(); k++)
        if (q_addr[k] !== base + k || q_we[k] !== w || (w && q_wd[k] !== wd[8 * k +: 8])) begin
          fails++; $display("FAIL rand%0d_xfer%0d got %h we=%0b d=%h exp %h we=%0b d=%h", i, k, q_addr[k], q_we[k], q_wd[k], base + k, w, wd[8 * k +: 8]);
        end
      if (!bad && w) for (int k = 0; k < n; k++) ref_mem[base + k] = wd[8 * k +: 8];
      exp_rdata = want;
      checks++; if (rdata !== exp_rdata) begin fails++; $display("FAIL rand%0d_rdata got %h exp %h", i, rdata, exp_rdata); end
    end
    ack_delay = 0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; memread = 1'b0; memwrite = 1'b0;
    dS = 2'b00; btX = 1'b0; addr = 32'h0; wdata = 32'h0;
    repeat (3) @(negedge clk);
    test_reset;
    test_word_load;
    test_byte_load;
    test_halfword_store;
    test_errors;
    test_reset_mid;
    test_start_while_busy;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
